// File: rtl/fir_out_quantizer.sv
// ---------------------------------------------------------------------------
// fir_out_quantizer
//
// Output stage for the parallel FIR filter. It takes the signed accumulator
// output and:
//   1. rounds it half-up (toward +inf) and arithmetically shifts it right
//      by SHIFT,
//   2. optionally decimates, keeping 1 of every DECIM samples,
//   3. saturates the result to OUT_W bits (or wraps it, see below),
//   4. buffers it in a DEPTH-entry FIFO that drives a valid/ready stream.
//
// Build option:
//   FIR_QUANT_SAT_EN  defined   -> saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
//                                  the clip flag is live.
//                     undefined -> no saturation logic. The low OUT_W bits
//                                  of the rounded value are written, so
//                                  out-of-range values wrap. clip is tied
//                                  to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_data      in   IN_W   signed FIR output sample
//   in_valid     in   in_data valid; there is no upstream backpressure
//   clear_flags  in   clears the sticky flags (a same-cycle set wins)
//   out_data     out  OUT_W  signed sample at the FIFO head (0 when empty)
//   out_valid    out  FIFO not empty
//   out_ready    in   consumer takes out_data this cycle
//   fifo_level   out  number of occupied FIFO entries
//   overflow     out  sticky: a sample was dropped because the FIFO was full
//   clip         out  sticky: a sample was saturated
// ---------------------------------------------------------------------------
module fir_out_quantizer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DECIM = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [IN_W-1:0]   in_data,
    input  logic                     in_valid,
    input  logic                     clear_flags,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     clip
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [CNT_W-1:0]    DEC_LAST  = CNT_W'(DECIM - 1);
    localparam logic [AW:0]         FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]       PTR_ONE   = AW'(1);
    localparam logic [AW:0]         LVL_ONE   = (AW + 1)'(1);
    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [IN_W:0] RND_BIAS = (IN_W + 1)'(1) << (SHIFT - 1);

`ifdef FIR_QUANT_SAT_EN
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W:0] SAT_MIN = -SAT_MAX - 1;
`endif

    // Round half-up then shift. One extra bit of headroom keeps the bias
    // add from overflowing at the top of the input range.
    function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        sum = $signed({x[IN_W-1], x}) + RND_BIAS;
        return sum >>> SHIFT;
    endfunction

`ifdef FIR_QUANT_SAT_EN
    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] r);
        if (r > SAT_MAX) begin
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (r < SAT_MIN) begin
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            return {1'b0, r[OUT_W-1:0]};
        end
    endfunction
`endif

    // ---- stage 1: round and shift ----------------------------------------
    logic                  vld_p1;
    logic signed [IN_W:0]  r_round_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_round_p1 <= round_shift(in_data);
        end
    end

    // ---- stage 2: decimate, quantize, FIFO write --------------------------
    logic [CNT_W-1:0] r_dec_cnt;
    logic             w_keep_p1;

    // The counter only moves on valid samples, so gaps in in_valid do not
    // disturb the decimation phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_cnt <= '0;
        end else if (vld_p1) begin
            if (r_dec_cnt == DEC_LAST) begin
                r_dec_cnt <= '0;
            end else begin
                r_dec_cnt <= r_dec_cnt + CNT_W'(1);
            end
        end
    end

    assign w_keep_p1 = vld_p1 && (r_dec_cnt == '0);

    logic signed [OUT_W-1:0] w_q_p1;
    logic                    w_clip_p1;

`ifdef FIR_QUANT_SAT_EN
    logic [OUT_W:0] w_sat_p1;
    assign w_sat_p1  = saturate(r_round_p1);
    assign w_q_p1    = w_sat_p1[OUT_W-1:0];
    assign w_clip_p1 = w_sat_p1[OUT_W];
`else
    // Wrapping build: upper bits of the rounded value are discarded.
    logic w_unused_hi;
    assign w_q_p1      = r_round_p1[OUT_W-1:0];
    assign w_clip_p1   = 1'b0;
    assign w_unused_hi = ^r_round_p1[IN_W:OUT_W];
`endif

    // FIFO control
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;
    logic signed [OUT_W-1:0] r_mem [DEPTH];

    // A full FIFO still accepts a write if the head leaves in the same cycle.
    assign w_rd   = (r_level != '0) && out_ready;
    assign w_wr   = w_keep_p1 && ((r_level != FULL_LVL) || w_rd);
    assign w_drop = w_keep_p1 && (r_level == FULL_LVL) && !w_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; out_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_q_p1;
        end
    end

    // Sticky flags: a set event takes priority over clear_flags.
    logic r_overflow;
    logic r_clip;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_clip     <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_keep_p1 && w_clip_p1) begin
                r_clip <= 1'b1;
            end else if (clear_flags) begin
                r_clip <= 1'b0;
            end
        end
    end

    // ---- outputs -----------------------------------------------------------
    assign out_valid  = (r_level != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
`ifdef FIR_QUANT_SAT_EN
    assign clip       = r_clip;
`else
    logic w_unused_clip;
    assign clip          = 1'b0;
    assign w_unused_clip = r_clip;
`endif

endmodule

// File: tb/tb_fir_out_quantizer.sv
module tb_fir_out_quantizer;

    localparam int SHIFT = 15;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with DECIM=1
    logic               reset = 1'b1;
    logic signed [31:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               clear_flags = 1'b0;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [3:0]         fifo_level;
    logic               overflow;
    logic               clip;

    // DUT with DECIM=3
    logic               reset3 = 1'b1;
    logic signed [31:0] in_data3 = '0;
    logic               in_valid3 = 1'b0;
    logic               clear_flags3 = 1'b0;
    logic signed [15:0] out_data3;
    logic               out_valid3;
    logic               out_ready3 = 1'b0;
    logic [3:0]         fifo_level3;
    logic               overflow3;
    logic               clip3;

    int checks = 0;
    int errors = 0;

    fir_out_quantizer #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .clear_flags(clear_flags), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow), .clip(clip)
    );

    fir_out_quantizer #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .reset(reset3), .in_data(in_data3), .in_valid(in_valid3),
        .clear_flags(clear_flags3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .fifo_level(fifo_level3), .overflow(overflow3), .clip(clip3)
    );

    // ---------------- reference model (DECIM=1 DUT) ----------------
    // Mathematical rounding: floor((x + 2^(S-1)) / 2^S) on 64-bit integers.
    function automatic longint ref_round(input longint x);
        longint d;
        longint s;
        d = longint'(1) <<< SHIFT;
        s = x + d / 2;
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function automatic logic signed [15:0] ref_quant(input longint r, output bit c);
        longint t;
        c = 1'b0;
`ifdef FIR_QUANT_SAT_EN
        if (r > 32767) begin
            c = 1'b1;
            return 16'sh7FFF;
        end
        if (r < -32768) begin
            c = 1'b1;
            return 16'sh8000;
        end
`endif
        t = r;
        return t[15:0];
    endfunction

    logic signed [15:0] m_q[$];
    bit                 m_pend_v = 1'b0;
    logic signed [31:0] m_pend_d = '0;
    bit                 m_ovf = 1'b0;
    bit                 m_clip = 1'b0;

    task automatic model_reset();
        m_q.delete();
        m_pend_v = 1'b0;
        m_ovf    = 1'b0;
        m_clip   = 1'b0;
    endtask

    // Drive one cycle on the DECIM=1 DUT and advance the model to match.
    task automatic step(input bit v, input logic signed [31:0] d, input bit rdy, input bit clr);
        bit rd, wr, c, ovf_ev, clip_ev;
        logic signed [15:0] qv;
        in_valid    = v;
        in_data     = d;
        out_ready   = rdy;
        clear_flags = clr;
        rd = (m_q.size() != 0) && rdy;
        wr = 1'b0; ovf_ev = 1'b0; clip_ev = 1'b0; qv = '0;
        if (m_pend_v) begin
            qv = ref_quant(ref_round(longint'(m_pend_d)), c);
            clip_ev = c;
            if (m_q.size() < DEPTH || rd) wr = 1'b1;
            else ovf_ev = 1'b1;
        end
        if (rd) void'(m_q.pop_front());
        if (wr) m_q.push_back(qv);
        m_clip   = clip_ev ? 1'b1 : (clr ? 1'b0 : m_clip);
        m_ovf    = ovf_ev  ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_pend_v = v;
        m_pend_d = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_flags = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step3(input bit v, input logic signed [31:0] d);
        in_valid3 = v;
        in_data3  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset3();
        in_valid3 = 1'b0; in_data3 = '0;
        reset3 = 1'b1;
        @(posedge clk);
        #1;
        reset3 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip got %0b want 0", clip); end
        if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    endtask

    task automatic test_rounding();
        logic signed [31:0] ins [6] = '{32'sd16384, 32'sd16383, 32'sd98304, -32'sd16384, -32'sd16385, -32'sd98304};
        logic signed [15:0] exps[6] = '{16'sd1, 16'sd0, 16'sd3, 16'sd0, -16'sd1, -16'sd3};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ins[i], 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL round_latency_%0d out_valid got %0b want 0", i, out_valid); end
            step(1'b0, '0, 1'b1, 1'b0);
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL round_valid_%0d got %0b want 1", i, out_valid); end
            if (out_data !== exps[i]) begin errors++; $display("FAIL round_data_%0d in %0d got %0d want %0d", i, ins[i], out_data, exps[i]); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
`ifdef FIR_QUANT_SAT_EN
        step(1'b1, 32'sh7FFF_FFFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks += 2;
        if (out_data !== 16'sh7FFF) begin errors++; $display("FAIL sat_pos got %h want 7fff", out_data); end
        if (clip !== 1'b1) begin errors++; $display("FAIL sat_pos_clip got %0b want 1", clip); end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'sh8000_0000, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (out_data !== 16'sh8000) begin errors++; $display("FAIL sat_neg got %h want 8000", out_data); end
        step(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (clip !== 1'b0) begin errors++; $display("FAIL sat_clear_clip got %0b want 0", clip); end
`else
        step(1'b1, 32'sh7FFF_FFFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0b want 1", out_valid); end
        if (out_data !== 16'sh0000) begin errors++; $display("FAIL wrap_data got %h want 0000", out_data); end
        if (clip !== 1'b0) begin errors++; $display("FAIL wrap_clip got %0b want 0", clip); end
        step(1'b0, '0, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_full_fifo();
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, k * 32768, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks += 2;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level got %0d want 8", fifo_level); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got %0b want 1", overflow); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (out_data !== 16'(k)) begin errors++; $display("FAIL drain_%0d got %0d want %0d", k, out_data, k); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", out_valid); end
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) step(1'b1, k * 32768, 1'b0, 1'b0);
        step(1'b1, 99 * 32768, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL refill_level got %0d want 8", fifo_level); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks += 3;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL rdwr_full_level got %0d want 8", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rdwr_full_overflow got %0b want 0", overflow); end
        if (out_data !== 16'sd2) begin errors++; $display("FAIL rdwr_full_head got %0d want 2", out_data); end
        for (int k = 2; k <= 8; k++) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (out_data !== 16'sd99) begin errors++; $display("FAIL rdwr_full_tail got %0d want 99", out_data); end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic signed [31:0] d;
        logic signed [15:0] exp_d;
        bit v, rdy, clr;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       d = $signed($urandom());
                1:       d = $signed(32'($urandom_range(0, 2097152))) - 32'sd1048576;
                default: d = $signed(32'($urandom_range(0, 65536))) - 32'sd32768;
            endcase
            rdy = (n < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step(v, d, rdy, clr);
            exp_d = (m_q.size() != 0) ? m_q[0] : 16'sd0;
            checks += 5;
            if (fifo_level !== 4'(m_q.size())) begin errors++; $display("FAIL rand_level cyc %0d got %0d want %0d", n, fifo_level, m_q.size()); end
            if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %0b", n, out_valid); end
            if (out_data !== exp_d) begin errors++; $display("FAIL rand_data cyc %0d got %0d want %0d", n, out_data, exp_d); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow cyc %0d got %0b want %0b", n, overflow, m_ovf); end
            if (clip !== m_clip) begin errors++; $display("FAIL rand_clip cyc %0d got %0b want %0b", n, clip, m_clip); end
        end
    endtask

    task automatic test_decimation();
        logic signed [15:0] got[$];
        logic signed [15:0] exp_q[$];
        bit c;
        do_reset3();
        out_ready3 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step3(1'b1, k * 32768);
            if (out_valid3) got.push_back(out_data3);
            if (k % 2 == 0) begin
                step3(1'b0, '0);
                if (out_valid3) got.push_back(out_data3);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step3(1'b0, '0);
            if (out_valid3) got.push_back(out_data3);
        end
        for (int k = 1; k <= 9; k++)
            if ((k - 1) % 3 == 0) exp_q.push_back(ref_quant(ref_round(longint'(k) * 32768), c));
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL decim_count got %0d want %0d", got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin errors++; $display("FAIL decim_out_%0d got %0d want %0d", i, got[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset3();
        out_ready3 = 1'b0;
        for (int k = 1; k <= 13; k++) step3(1'b1, k * 32768);
        step3(1'b0, '0);
        checks++;
        if (fifo_level3 !== 4'd5) begin errors++; $display("FAIL mid_pre_level got %0d want 5", fifo_level3); end
        do_reset3();
        checks += 4;
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", out_valid3); end
        if (fifo_level3 !== 4'd0) begin errors++; $display("FAIL mid_level got %0d want 0", fifo_level3); end
        if (overflow3 !== 1'b0) begin errors++; $display("FAIL mid_overflow got %0b want 0", overflow3); end
        if (clip3 !== 1'b0) begin errors++; $display("FAIL mid_clip got %0b want 0", clip3); end
        step3(1'b1, 5 * 32768);
        checks++;
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL mid_latency got %0b want 0", out_valid3); end
        step3(1'b0, '0);
        checks += 2;
        if (out_valid3 !== 1'b1) begin errors++; $display("FAIL mid_next_valid got %0b want 1", out_valid3); end
        if (out_data3 !== 16'sd5) begin errors++; $display("FAIL mid_next_data got %0d want 5", out_data3); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset3 = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_full_fifo();
        test_random();
        test_decimation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
